mult_hilo_ctrl: RTL and testbench

//  Sequencer and HI/LO register file between the MIPS execute stage and the

---
 rtl/mult_hilo_ctrl.sv | 118 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and sequencer for the iterative multiplier: issue, wait, capture.
// Optional build macro MULT_SIGNED_EN adds req_signed and sign-magnitude handling.
module mult_hilo_ctrl #(
  parameter int WIDTH       = 4,
  parameter int MUL_LATENCY = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
`ifdef MULT_SIGNED_EN
  input  logic               req_signed,
`endif
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               rd_hi,
  input  logic               rd_lo,
  input  logic               wr_hi,
  input  logic               wr_lo,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               stall,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  // cnt also increments on the exit edge, so it must hold MUL_LATENCY
  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;

`ifdef MULT_SIGNED_EN
  logic neg_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
    negate = ~v + PW'(1);
  endfunction
`endif

  assign busy      = (state_r != IDLE);
  assign req_ready = (state_r == IDLE);
  assign stall     = busy & (rd_hi | rd_lo | wr_hi | wr_lo);

  // Sequencer, HI/LO storage and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      hi        <= '0;
      lo        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      done      <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_r     <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (req_valid) begin
`ifdef MULT_SIGNED_EN
            mul_a <= req_signed ? magnitude(req_a) : req_a;
            mul_b <= req_signed ? magnitude(req_b) : req_b;
            neg_r <= req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
`else
            mul_a <= req_a;
            mul_b <= req_b;
`endif
            mul_start <= 1'b1;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r   <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(MUL_LATENCY - 1)) state_r <= CAPTURE;
        end
        CAPTURE: begin
`ifdef MULT_SIGNED_EN
          {hi, lo} <= neg_r ? negate(mul_product) : mul_product;
`else
          {hi, lo} <= mul_product;
`endif
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl (WIDTH=4, MUL_LATENCY=4) with a latency-accurate multiplier stand-in.
module tb_mult_hilo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
`ifdef MULT_SIGNED_EN
  logic       req_signed = 1'b0;
`endif
  logic       mul_start;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_product = 8'hA5;
  logic       rd_hi = 1'b0, rd_lo = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic [3:0] hi, lo;
  logic       busy, stall, done;

  int checks = 0;
  int failures = 0;

  mult_hilo_ctrl #(.WIDTH(4), .MUL_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef MULT_SIGNED_EN
    .req_signed(req_signed),
`endif
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: garbage until 4 edges after the start-sampling edge
  logic [3:0] pa = 4'h0, pb = 4'h0;
  int lat = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      pa <= mul_a; pb <= mul_b; lat <= 1; mul_product <= 8'hA5;
    end else if (lat == 4) begin
      mul_product <= {4'h0, pa} * {4'h0, pb}; lat <= 0;
    end else if (lat != 0) begin
      lat <= lat + 1;
    end
  end

  task automatic wait_done(output int n, output int starts);
    n = 0; starts = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mul_start) starts++;
      if (done) begin n = i; break; end
    end
  endtask

  task automatic run_mult(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ea,
                          input logic [3:0] eb, input logic [3:0] ehi, input logic [3:0] elo);
    int n, s;
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL start_pulse a=%h b=%h: got %b want 1", a, b, mul_start); end
    checks++; if ({busy, req_ready} !== 2'b10) begin failures++; $display("FAIL busy_ready a=%h b=%h: got %b want 10", a, b, {busy, req_ready}); end
    checks++; if ({mul_a, mul_b} !== {ea, eb}) begin failures++; $display("FAIL operands a=%h b=%h: got %h want %h", a, b, {mul_a, mul_b}, {ea, eb}); end
    wait_done(n, s);
    checks++; if (n !== 6) begin failures++; $display("FAIL latency a=%h b=%h: got %0d want 6", a, b, n); end
    checks++; if (s !== 0) begin failures++; $display("FAIL extra_start a=%h b=%h: got %0d want 0", a, b, s); end
    checks++; if ({hi, lo} !== {ehi, elo}) begin failures++; $display("FAIL hilo a=%h b=%h: got %h want %h", a, b, {hi, lo}, {ehi, elo}); end
    @(posedge clk); #1;
    checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL done_once a=%h b=%h: got %b want 00", a, b, {done, busy}); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({hi, lo, mul_a, mul_b} !== 16'h0000) begin failures++; $display("FAIL reset_regs: got %h want 0000", {hi, lo, mul_a, mul_b}); end
    checks++; if ({mul_start, done, busy, req_ready, stall} !== 5'b00010) begin failures++; $display("FAIL reset_ctrl: got %b want 00010", {mul_start, done, busy, req_ready, stall}); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_mult(4'd5, 4'd3, 4'd5, 4'd3, 4'h0, 4'hF);
    run_mult(4'd15, 4'd15, 4'd15, 4'd15, 4'hE, 4'h1);
    run_mult(4'd0, 4'd3, 4'd0, 4'd3, 4'h0, 4'h0);
  endtask

  task automatic test_write_idle();
    int n, s;
    wr_lo = 1'b1; wr_data = 4'h9; rd_hi = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall: got %b want 0", stall); end
    @(posedge clk); #1; wr_lo = 1'b0; rd_hi = 1'b0;
    checks++; if ({hi, lo} !== 8'h09) begin failures++; $display("FAIL mtlo_idle: got %h want 09", {hi, lo}); end
    wr_hi = 1'b1; wr_data = 4'hA; req_a = 4'd0; req_b = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1; wr_hi = 1'b0; req_valid = 1'b0;
    checks++; if ({hi, lo} !== 8'hA9) begin failures++; $display("FAIL mthi_with_req: got %h want A9", {hi, lo}); end
    wait_done(n, s);
    checks++; if ({hi, lo} !== 8'h00) begin failures++; $display("FAIL mult_overwrites: got %h want 00", {hi, lo}); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_write();
    int n, s;
    req_a = 4'd5; req_b = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rd_hi = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rd_stall: got %b want 1", stall); end
    rd_hi = 1'b0; wr_hi = 1'b1; wr_data = 4'h7; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wr_stall: got %b want 1", stall); end
    wait_done(n, s);
    checks++; if (n !== 4) begin failures++; $display("FAIL stall_latency: got %0d want 4", n); end
    checks++; if ({hi, lo, stall} !== {8'h0F, 1'b0}) begin failures++; $display("FAIL write_dropped: got %h/%b want 0F/0", {hi, lo}, stall); end
    @(posedge clk); #1; wr_hi = 1'b0;
    checks++; if ({hi, lo} !== 8'h7F) begin failures++; $display("FAIL held_write: got %h want 7F", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    int n, s, bad;
    bad = 0; n = 0;
    req_a = 4'd2; req_b = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      if (busy && req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ready_while_busy: got %0d cycles want 0", bad); end
    checks++; if ({n[3:0], hi, lo, req_ready} !== {4'd6, 8'h06, 1'b1}) begin failures++; $display("FAIL b2b_first: got n=%0d hilo=%h rdy=%b want 6/06/1", n, {hi, lo}, req_ready); end
    req_a = 4'd4; req_b = 4'd4;
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if ({mul_start, mul_a, mul_b} !== {1'b1, 8'h44}) begin failures++; $display("FAIL b2b_accept: got %b/%h want 1/44", mul_start, {mul_a, mul_b}); end
    wait_done(n, s);
    checks++; if ({n[3:0], hi, lo} !== {4'd6, 8'h10}) begin failures++; $display("FAIL b2b_second: got n=%0d hilo=%h want 6/10", n, {hi, lo}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    req_a = 4'd15; req_b = 4'd15; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if ({busy, mul_start, hi, lo} !== 10'h000) begin failures++; $display("FAIL async_reset: got %b/%b/%h want 0/0/00", busy, mul_start, {hi, lo}); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    run_mult(4'd15, 4'd15, 4'd15, 4'd15, 4'hE, 4'h1);
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    req_signed = 1'b1;
    run_mult(4'hD, 4'h5, 4'h3, 4'h5, 4'hF, 4'h1);
    run_mult(4'h8, 4'h8, 4'h8, 4'h8, 4'h4, 4'h0);
    req_signed = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_write_idle();
    test_stall_write();
    test_back_to_back();
    test_reset_midop();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
